uart_receiver: RTL

Receive side of the SoC serial link, paired with the existing UART transmitter: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle high, no parity. Runs on an oversampling clock at OVERSAMPLE × baud. Recovers bytes from the asynchronous line and holds each byte in a valid/ack output register for the bus-side consumer. Supports back-to-back frames as produced by the transmitter when its launch enable is held high (10-bit frames with no idle gap).

---
 rtl/uart_receiver.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receive path: 8N1 frames on an OVERSAMPLE x baud clock,
// delivered into a valid/ack holding register.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_receive_i,
    input  logic       uart_i,
    input  logic       rx_ack_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_error_o,
    output logic       overrun_o,
    output logic       busy_o,
    output logic [3:0] r_data_counter_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          sync_meta_q, s_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          deliver;
    logic          ferr_d;
    logic [7:0]    data_d;
    logic          valid_d;
    logic          ovr_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_meta_q <= 1'b1;
            s_q         <= 1'b1;
        end else begin
            sync_meta_q <= uart_i;
            s_q         <= sync_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + 1'b1;
        cnt_d   = r_data_counter_o;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (!s_q) state_d = S_START;
            end
            S_START: begin
                if (tick_q == TICK_HALF)
                    state_d = s_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick_q == TICK_LAST) begin
                    shift_d = {s_q, shift_q[7:1]};
                    cnt_d   = r_data_counter_o + 4'd1;
                    tick_d  = '0;
                    if (r_data_counter_o == 4'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_q == TICK_LAST) begin
                    if (s_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) tick_d = '0;
        if (state_d == S_STOP || state_d == S_BREAK)
            cnt_d = 4'd9;
        else if (state_d != S_DATA)
            cnt_d = 4'd0;

        // Disable abandons the frame silently; the holding register is kept.
        if (!en_receive_i) begin
            state_d = S_IDLE;
            tick_d  = '0;
            cnt_d   = 4'd0;
            deliver = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_comb begin
        data_d  = rx_data_o;
        valid_d = rx_valid_o;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (!rx_valid_o || rx_ack_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            tick_q           <= '0;
            shift_q          <= '0;
            r_data_counter_o <= '0;
            busy_o           <= 1'b0;
            frame_error_o    <= 1'b0;
            overrun_o        <= 1'b0;
            rx_data_o        <= '0;
            rx_valid_o       <= 1'b0;
        end else begin
            state_q          <= state_d;
            tick_q           <= tick_d;
            shift_q          <= shift_d;
            r_data_counter_o <= cnt_d;
            busy_o           <= (state_d != S_IDLE);
            frame_error_o    <= ferr_d;
            overrun_o        <= ovr_d;
            rx_data_o        <= data_d;
            rx_valid_o       <= valid_d;
        end
    end

endmodule
